vga_axil_regfile: RTL
=====================

Name: vga_axil_regfile

Overview:
- Parametrised AXI4-Lite slave register file for the VGA control plane.
- Generalises the fixed 32-bit AXI-Lite definitions to configurable address/data width, register count and RW/RO split.
- Adds write strobes, per-register write pulses and SLVERR decode.
- Sits between the system interconnect and the VGA timing/framebuffer control logic.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width in bits.
- DATA_WIDTH, 32, AXI-Lite data width in bits; must be 32 or 64.
- ADDR_LSB, 2, low byte-address bits dropped to form the word index; must equal log2(DATA_WIDTH/8).
- NUM_RW, 4, number of read/write registers, at word indices 0..NUM_RW-1.
- NUM_RO, 2, number of read-only registers, at word indices NUM_RW..NUM_RW+NUM_RO-1.

Ports:
- clk_i in 1: clock; all logic on the rising edge.
- rst_i in 1: asynchronous active-high reset.
- awaddr_i in ADDR_WIDTH; awvalid_i in 1; awready_o out 1: write-address channel.
- wdata_i in DATA_WIDTH; wstrb_i in DATA_WIDTH/8; wvalid_i in 1; wready_o out 1: write-data channel.
- bresp_o out 2; bvalid_o out 1; bready_i in 1: write-response channel.
- araddr_i in ADDR_WIDTH; arvalid_i in 1; arready_o out 1: read-address channel.
- rdata_o out DATA_WIDTH; rresp_o out 2; rvalid_o out 1; rready_i in 1: read-data channel.
- rw_regs_o out NUM_RW*DATA_WIDTH: RW register contents; register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse_o out NUM_RW: one-cycle pulse per RW register on a successful write.
- ro_data_i in NUM_RO*DATA_WIDTH: live values returned by reads of the RO registers.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - All RW registers = 0.
  - awready_o=wready_o=arready_o=1.
  - bvalid_o=rvalid_o=0; bresp_o=rresp_o=OKAY(2'b00); rdata_o=0; wr_pulse_o=0.
  - Any held AW/W beat or pending response is discarded.
- Word index: idx = addr >> ADDR_LSB. Bits below ADDR_LSB are ignored; no unaligned error is raised.
- Write FSM states: W_IDLE, W_RESP. Address and data are captured independently in W_IDLE.
  - awready_o = W_IDLE and no AW held. wready_o = W_IDLE and no W held.
  - Edge where both are held, or arrive in the same cycle:
    - If idx < NUM_RW: byte lanes with wstrb bit set are updated; wr_pulse_o[idx]=1 for the next cycle only (even when wstrb=0); bresp=OKAY.
    - If idx is RO or out of range: no register change, no pulse, bresp=SLVERR(2'b10).
    - In both cases the FSM moves to W_RESP with bvalid_o=1 the next cycle.
  - Minimum latency: AW+W in the same cycle gives bvalid_o one cycle later.
  - W_RESP: bvalid_o and bresp_o stay stable until bready_i=1. That edge returns the FSM to W_IDLE and clears the holders; the ready signals rise the following cycle.
- Read FSM states: R_IDLE, R_RESP.
  - arready_o = R_IDLE.
  - On the AR handshake:
    - rdata_o is registered: RW contents, ro_data_i slice, or 0 when out of range.
    - rresp_o = OKAY, or SLVERR when out of range.
    - rvalid_o=1 the next cycle.
  - R_RESP: rdata_o, rresp_o and rvalid_o are held stable until rready_i=1, then the FSM returns to R_IDLE.
  - RO data is sampled at the AR handshake edge, not while rvalid_o is held.
- Channel independence: read and write proceed concurrently.
  - A read accepted on the same edge that a write to the same register commits returns the pre-write value.
- Back-pressure: with bready_i=0 indefinitely, further AW/W beats are not accepted (at most one beat of each is held). Read behaves the same way with rready_i=0.
- Reset mid-transaction aborts the transaction; the bus must not see a stale response after reset.

Test Plan:
1. Reset, then AW addr 0x4 + W 0xDEADBEEF strb 0xF in the same cycle, bready=1 -> bvalid next cycle, bresp=00; reg1=0xDEADBEEF; wr_pulse_o=4'b0010 for 1 cycle.
2. W data 0x11223344 strb 0x5 arriving 3 cycles before AW addr 0x0 (reg0=0) -> write commits only after AW; reg0=0x00220044; bresp=00.
3. Write to addr 0x10 (RO, idx 4) and to addr 0x40 (idx 16) -> bresp=10 for both; all RW registers unchanged; no pulse. Read of 0x40 -> rresp=10, rdata=0.
4. ro_data_i slice 0 = 0xA5A5A5A5, AR addr 0x10 -> rdata=0xA5A5A5A5, rresp=00. ro_data_i changed while rready=0 for 5 cycles -> rdata remains 0xA5A5A5A5.
5. bready=0 for 10 cycles after a write -> awready/wready stay 0; a second AW is not accepted until one cycle after bready=1.
6. Assert rst_i while bvalid=1 and rvalid=1 -> both drop immediately; registers=0; after release, a fresh read of addr 0x4 returns 0.

Source files
------------

// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile
//   AXI4-Lite slave register file for the VGA control plane. Word indices
//   0..NUM_RW-1 are read/write registers exported on rw_regs_o, indices
//   NUM_RW..NUM_RW+NUM_RO-1 return the live ro_data_i slices, and anything
//   else answers SLVERR (reads return zero).
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   aw*/w*/b*               AXI-Lite write address / data / response channels
//   ar*/r*                  AXI-Lite read address / data channels
//   rw_regs_o               flattened RW registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse_o              one-cycle pulse per RW register after an accepted write
//   ro_data_i               flattened read-only values, sampled at AR handshake
module vga_axil_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LSB   = 2,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [ADDR_WIDTH-1:0]        araddr_i,
  input  logic                         arvalid_i,
  output logic                         arready_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [1:0]                   rresp_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs_o,
  output logic [NUM_RW-1:0]            wr_pulse_o,
  input  logic [NUM_RO*DATA_WIDTH-1:0] ro_data_i
);

  localparam int IDX_W  = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t                w_state_r;
  r_state_t                r_state_r;
  logic                    aw_held_r;
  logic [IDX_W-1:0]        aw_idx_r;
  logic                    w_held_r;
  logic [DATA_WIDTH-1:0]   w_data_r;
  logic [STRB_W-1:0]       w_strb_r;
  logic                    awready_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic [1:0]              bresp_r;
  logic [NUM_RW-1:0]       wr_pulse_r;
  logic [DATA_WIDTH-1:0]   rw_regs_r [NUM_RW];
  logic                    arready_r;
  logic                    rvalid_r;
  logic [1:0]              rresp_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    ar_hs_s;
  logic [IDX_W-1:0]        wr_idx_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [STRB_W-1:0]       wr_strb_s;
  logic                    wr_go_s;
  logic                    wr_hit_s;
  logic [IDX_W-1:0]        ar_idx_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic [1:0]              rd_resp_s;
  logic                    unused_addr_bits_s;

  // Sub-word address bits carry no meaning (no unaligned error).
  assign unused_addr_bits_s = ^{awaddr_i[ADDR_LSB-1:0], araddr_i[ADDR_LSB-1:0]};

  // Write-side handshakes and the effective beat: a held beat wins over the bus.
  always_comb begin
    aw_hs_s = awvalid_i && awready_r;
    w_hs_s  = wvalid_i && wready_r;
    if (aw_held_r) begin
      wr_idx_s = aw_idx_r;
    end else begin
      wr_idx_s = awaddr_i[ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_held_r) begin
      wr_data_s = w_data_r;
      wr_strb_s = w_strb_r;
    end else begin
      wr_data_s = wdata_i;
      wr_strb_s = wstrb_i;
    end
    wr_go_s  = (w_state_r == W_IDLE) && (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    wr_hit_s = (wr_idx_s < IDX_W'(NUM_RW));
  end

  // Write FSM: collects AW and W independently, commits once both are present.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_r  <= W_IDLE;
      aw_held_r  <= 1'b0;
      aw_idx_r   <= {IDX_W{1'b0}};
      w_held_r   <= 1'b0;
      w_data_r   <= {DATA_WIDTH{1'b0}};
      w_strb_r   <= {STRB_W{1'b0}};
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
      wr_pulse_r <= {NUM_RW{1'b0}};
    end else begin
      wr_pulse_r <= {NUM_RW{1'b0}};
      case (w_state_r)
        W_IDLE: begin
          if (wr_go_s) begin
            w_state_r <= W_RESP;
            bvalid_r  <= 1'b1;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            if (wr_hit_s) begin
              bresp_r <= RESP_OKAY;
              for (int k = 0; k < NUM_RW; k++) begin
                if (wr_idx_s == IDX_W'(k)) begin
                  wr_pulse_r[k] <= 1'b1;
                end
              end
            end else begin
              bresp_r <= RESP_SLVERR;
            end
          end else begin
            if (aw_hs_s) begin
              aw_held_r <= 1'b1;
              aw_idx_r  <= awaddr_i[ADDR_WIDTH-1:ADDR_LSB];
              awready_r <= 1'b0;
            end
            if (w_hs_s) begin
              w_held_r <= 1'b1;
              w_data_r <= wdata_i;
              w_strb_r <= wstrb_i;
              wready_r <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (bready_i) begin
            w_state_r <= W_IDLE;
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          bvalid_r  <= 1'b0;
          awready_r <= 1'b1;
          wready_r  <= 1'b1;
        end
      endcase
    end
  end

  // RW register storage with byte-lane strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_RW; k++) begin
        rw_regs_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_RW; k++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_go_s && (wr_idx_s == IDX_W'(k)) && wr_strb_s[b]) begin
            rw_regs_r[k][b*8 +: 8] <= wr_data_s[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read decode: RW registers, then RO slices, otherwise zero with SLVERR.
  always_comb begin
    ar_hs_s   = arvalid_i && arready_r;
    ar_idx_s  = araddr_i[ADDR_WIDTH-1:ADDR_LSB];
    rd_data_s = {DATA_WIDTH{1'b0}};
    rd_resp_s = RESP_SLVERR;
    for (int k = 0; k < NUM_RW; k++) begin
      rd_data_s = (ar_idx_s == IDX_W'(k)) ? rw_regs_r[k] : rd_data_s;
      rd_resp_s = (ar_idx_s == IDX_W'(k)) ? RESP_OKAY : rd_resp_s;
    end
    for (int k = 0; k < NUM_RO; k++) begin
      rd_data_s = (ar_idx_s == IDX_W'(NUM_RW + k)) ? ro_data_i[k*DATA_WIDTH +: DATA_WIDTH] : rd_data_s;
      rd_resp_s = (ar_idx_s == IDX_W'(NUM_RW + k)) ? RESP_OKAY : rd_resp_s;
    end
  end

  // Read FSM: registers the decoded word at AR handshake and holds it until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rresp_r   <= RESP_OKAY;
      rdata_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            r_state_r <= R_RESP;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rresp_r   <= rd_resp_s;
            rdata_r   <= rd_data_s;
          end
        end
        R_RESP: begin
          if (rready_i) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  assign awready_o  = awready_r;
  assign wready_o   = wready_r;
  assign bvalid_o   = bvalid_r;
  assign bresp_o    = bresp_r;
  assign arready_o  = arready_r;
  assign rvalid_o   = rvalid_r;
  assign rresp_o    = rresp_r;
  assign rdata_o    = rdata_r;
  assign wr_pulse_o = wr_pulse_r;

  for (genvar k = 0; k < NUM_RW; k++) begin : g_rw_out
    assign rw_regs_o[k*DATA_WIDTH +: DATA_WIDTH] = rw_regs_r[k];
  end

endmodule
